unidade_controle_rodadas: RTL and testbench
===========================================

UNIDADE_CONTROLE_RODADAS -- requirements
Module: unidade_controle_rodadas

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 5000: max cycles spent in espera_jogada before timeout; legal range 2..2^TW-1.
REQ-002 Parameter TW, default 13: width of internal timeout counter.
REQ-003 clock  input  1  system clock, rising-edge.
REQ-004 reset  input  1  asynchronous, active-high; forces state inicial.
REQ-005 iniciar  input  1  start/restart game request, level-sampled.
REQ-006 jogada  input  1  one-cycle pulse: player pressed a key.
REQ-007 igual  input  1  registered play equals memory word at current address.
REQ-008 fim_rodada  input  1  address counter equals current round limit.
REQ-009 fim_jogo  input  1  round-limit counter at last round.
REQ-010 zeraE / contaE  output  1 each  clear / increment address counter.
REQ-011 zeraL / contaL  output  1 each  clear / increment round-limit counter.
REQ-012 zeraR / registraR  output  1 each  clear / load play register.
REQ-013 acertou, errou, timeout, pronto  output  1 each  game-result flags.
REQ-014 db_estado  output  4  current state code, debug.

Function
REQ-015 Moore FSM; all outputs decoded from current state only.
REQ-016 States/codes: inicial 0, preparacao 1, inicia_rodada 2, espera_jogada 3, registra 4, comparacao 5, proxima_jogada 6, proxima_rodada 7, fim_acertou A, fim_errou E, fim_timeout D.
REQ-017 inicial -> preparacao if iniciar, else hold.
REQ-018 preparacao -> inicia_rodada unconditionally.
REQ-019 inicia_rodada -> espera_jogada unconditionally.
REQ-020 espera_jogada -> registra if jogada; -> fim_timeout per REQ-031; else hold.
REQ-021 registra -> comparacao unconditionally.
REQ-022 comparacao: ~igual -> fim_errou; igual & fim_rodada & fim_jogo -> fim_acertou; igual & fim_rodada & ~fim_jogo -> proxima_rodada; igual & ~fim_rodada -> proxima_jogada.
REQ-023 proxima_jogada -> espera_jogada; proxima_rodada -> inicia_rodada.
REQ-024 fim_acertou, fim_errou, fim_timeout -> preparacao if iniciar, else hold.
REQ-025 Unused 4-bit codes -> inicial next cycle; db_estado = F while in them.
REQ-026 zeraE=1 in inicial, preparacao, inicia_rodada; zeraL=1 and zeraR=1 in inicial, preparacao.
REQ-027 contaE=1 only in proxima_jogada; contaL=1 only in proxima_rodada; registraR=1 only in registra.
REQ-028 pronto=1 in all three fim states; acertou only fim_acertou; errou only fim_errou; timeout only fim_timeout.
REQ-029 Latency: jogada sampled in espera_jogada -> result state reached exactly 3 cycles later (registra, comparacao, next).

Reset
REQ-030 On reset: state inicial, timeout counter 0; outputs zeraE=zeraL=zeraR=1, all others 0, db_estado=0; reset mid-game abandons the round immediately, no result flag asserted.

Configuration
REQ-031 Macro UNIDADE_CONTROLE_TIMEOUT_EN defined: TW-bit counter cleared in every state except espera_jogada, increments each espera_jogada cycle without jogada; at count TIMEOUT_CYCLES-1 with jogada=0 -> fim_timeout; jogada in same cycle wins (-> registra).
REQ-032 Macro undefined: no counter, timeout tied 0, fim_timeout unreachable, espera_jogada waits indefinitely; TIMEOUT_CYCLES/TW ignored.

Verification
REQ-033 Reset high mid-comparacao -> db_estado=0 asynchronously, zeraE=zeraL=zeraR=1, pronto=0.
REQ-034 iniciar pulse, 2 rounds (fim_jogo high on round 2), all igual=1 -> states 1,2,3,4,5,7,2,3,4,5,6,3,4,5,A; acertou=pronto=1.
REQ-035 Round 1, jogada with igual=0 -> db_estado E three cycles after jogada; errou=1, contaE never pulsed.
REQ-036 TIMEOUT_EN, TIMEOUT_CYCLES=8, no jogada -> fim_timeout (D) after 8 espera_jogada cycles; timeout=pronto=1.
REQ-037 TIMEOUT_EN, TIMEOUT_CYCLES=8, jogada on 8th cycle -> registra, no timeout; without macro, 10000 idle cycles -> stays state 3.
REQ-038 From fim_errou, iniciar=1 -> preparacao, zeraL=1, errou cleared next cycle.

Source files
------------

// File: rtl/unidade_controle_rodadas.sv
// Round control unit for the memory game: Moore FSM driving the address, round-limit and play-register datapath.
// Optional play timeout enabled by defining UNIDADE_CONTROLE_TIMEOUT_EN.
module unidade_controle_rodadas #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int TW             = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fim_rodada,
  input  logic       fim_jogo,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       registraR,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam logic [3:0] inicial        = 4'h0;
  localparam logic [3:0] preparacao     = 4'h1;
  localparam logic [3:0] inicia_rodada  = 4'h2;
  localparam logic [3:0] espera_jogada  = 4'h3;
  localparam logic [3:0] registra       = 4'h4;
  localparam logic [3:0] comparacao     = 4'h5;
  localparam logic [3:0] proxima_jogada = 4'h6;
  localparam logic [3:0] proxima_rodada = 4'h7;
  localparam logic [3:0] fim_acertou    = 4'hA;
  localparam logic [3:0] fim_timeout    = 4'hD;
  localparam logic [3:0] fim_errou      = 4'hE;

  logic [3:0] estado;
  logic [3:0] proximo;
  logic       expirou;

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
  localparam bit timeout_on = 1'b1;

  // Counts idle cycles in espera_jogada; any other state, or a play, restarts it.
  logic [TW-1:0] contagem;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      contagem <= '0;
    else if (estado == espera_jogada && !jogada)
      contagem <= contagem + TW'(1);
    else
      contagem <= '0;
  end

  assign expirou = (estado == espera_jogada) && !jogada &&
                   (contagem == TW'(TIMEOUT_CYCLES - 1));
`else
  localparam bit timeout_on = 1'b0;
  localparam int unused_params = TIMEOUT_CYCLES + TW;

  assign expirou = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      estado <= inicial;
    else
      estado <= proximo;
  end

  always_comb begin
    proximo = inicial;
    case (estado)
      inicial:        proximo = iniciar ? preparacao : inicial;
      preparacao:     proximo = inicia_rodada;
      inicia_rodada:  proximo = espera_jogada;
      // A play arriving on the last allowed cycle takes priority over the timeout.
      espera_jogada: begin
        if (jogada)
          proximo = registra;
        else if (expirou)
          proximo = fim_timeout;
        else
          proximo = espera_jogada;
      end
      registra:       proximo = comparacao;
      comparacao: begin
        if (!igual)
          proximo = fim_errou;
        else if (!fim_rodada)
          proximo = proxima_jogada;
        else if (fim_jogo)
          proximo = fim_acertou;
        else
          proximo = proxima_rodada;
      end
      proxima_jogada: proximo = espera_jogada;
      proxima_rodada: proximo = inicia_rodada;
      fim_acertou:    proximo = iniciar ? preparacao : fim_acertou;
      fim_errou:      proximo = iniciar ? preparacao : fim_errou;
      fim_timeout:    proximo = iniciar ? preparacao : fim_timeout;
      default:        proximo = inicial;
    endcase
  end

  always_comb begin
    zeraE     = 1'b0;
    contaE    = 1'b0;
    zeraL     = 1'b0;
    contaL    = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    timeout   = 1'b0;
    pronto    = 1'b0;
    case (estado)
      inicial, preparacao: begin
        zeraE = 1'b1;
        zeraL = 1'b1;
        zeraR = 1'b1;
      end
      inicia_rodada:  zeraE     = 1'b1;
      registra:       registraR = 1'b1;
      proxima_jogada: contaE    = 1'b1;
      proxima_rodada: contaL    = 1'b1;
      fim_acertou: begin
        acertou = 1'b1;
        pronto  = 1'b1;
      end
      fim_errou: begin
        errou  = 1'b1;
        pronto = 1'b1;
      end
      fim_timeout: begin
        timeout = timeout_on;
        pronto  = 1'b1;
      end
      default: ;
    endcase
  end

  // Illegal encodings are flagged as F so a corrupted state is visible on the debug port.
  always_comb begin
    case (estado)
      inicial, preparacao, inicia_rodada, espera_jogada, registra, comparacao,
      proxima_jogada, proxima_rodada, fim_acertou, fim_errou, fim_timeout:
        db_estado = estado;
      default:
        db_estado = 4'hF;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Self-checking bench for unidade_controle_rodadas: directed and randomized games checked against a game-level model.
// Timeout scenarios follow whether UNIDADE_CONTROLE_TIMEOUT_EN is defined.
module tb_unidade_controle_rodadas;

   localparam int TO = 8;

   logic clock = 1'b0;
   logic reset;
   logic iniciar, jogada, igual, fim_rodada, fim_jogo;
   logic zeraE, contaE, zeraL, contaL, zeraR, registraR;
   logic acertou, errou, timeout, pronto;
   logic [3:0] db_estado;
   logic [9:0] flags;

   int checks = 0;
   int errors = 0;
   int addrCnt, limCnt;

   always #5 clock = ~clock;

   unidade_controle_rodadas #(.TIMEOUT_CYCLES(TO), .TW(13)) dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
      .igual(igual), .fim_rodada(fim_rodada), .fim_jogo(fim_jogo),
      .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
      .zeraR(zeraR), .registraR(registraR), .acertou(acertou), .errou(errou),
      .timeout(timeout), .pronto(pronto), .db_estado(db_estado)
   );

   assign flags = {zeraE, contaE, zeraL, contaL, zeraR, registraR, acertou, errou, timeout, pronto};

   // Bench-side datapath: address and round-limit counters driven by the DUT's control outputs.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         addrCnt <= 0;
         limCnt  <= 0;
      end else begin
         if (zeraE) addrCnt <= 0;
         else if (contaE) addrCnt <= addrCnt + 1;
         if (zeraL) limCnt <= 0;
         else if (contaL) limCnt <= limCnt + 1;
      end
   end

   // Output table per state code, bit order matches the flags vector.
   function automatic logic [9:0] expectedFlags(input logic [3:0] code);
      logic zE, cE, zL, cL, zR, rR, ac, er, to, pr;
      {zE, cE, zL, cL, zR, rR, ac, er, to, pr} = '0;
      case (code)
         4'h0, 4'h1: begin zE = 1; zL = 1; zR = 1; end
         4'h2: zE = 1;
         4'h4: rR = 1;
         4'h6: cE = 1;
         4'h7: cL = 1;
         4'hA: begin ac = 1; pr = 1; end
         4'hE: begin er = 1; pr = 1; end
         4'hD: begin to = 1; pr = 1; end
         default: ;
      endcase
      return {zE, cE, zL, cL, zR, rR, ac, er, to, pr};
   endfunction

   task automatic applyStimulus(input logic ini, input logic jog, input logic ig,
                                input logic fr, input logic fj);
      iniciar    = ini;
      jogada     = jog;
      igual      = ig;
      fim_rodada = fr;
      fim_jogo   = fj;
   endtask

   task automatic checkOutput(input string tag, input logic [3:0] expCode);
      checks++;
      assert (db_estado === expCode) else begin
         errors++;
         $error("[TB] FAIL %s db_estado: got %h expected %h", tag, db_estado, expCode);
      end
      checks++;
      assert (flags === expectedFlags(expCode)) else begin
         errors++;
         $error("[TB] FAIL %s flags: got %b expected %b", tag, flags, expectedFlags(expCode));
      end
   endtask

   task automatic checkCounters(input string tag, input int expAddr, input int expLim);
      checks++;
      assert (addrCnt === expAddr && limCnt === expLim) else begin
         errors++;
         $error("[TB] FAIL %s counters: got addr=%0d lim=%0d expected addr=%0d lim=%0d",
                tag, addrCnt, limCnt, expAddr, expLim);
      end
   endtask

   task automatic stepExpect(input string tag, input logic [3:0] expCode);
      @(posedge clock);
      #1;
      checkOutput(tag, expCode);
   endtask

   task automatic holdResult(input logic [3:0] code);
      applyStimulus(0, 0, 0, 0, 0);
      repeat (2) stepExpect("hold_result", code);
   endtask

   // Plays one game: round r needs r+1 correct plays; errRound/errPlay select the wrong play (-1 = none).
   task automatic playGame(input int nRounds, input int errRound, input int errPlay, input int maxWait);
      logic ok;
      applyStimulus(1, 0, 0, 0, 0);
      stepExpect("preparacao", 4'h1);
      applyStimulus(0, 0, 0, 0, 0);
      stepExpect("inicia_rodada", 4'h2);
      for (int r = 0; r < nRounds; r++) begin
         for (int j = 0; j <= r; j++) begin
            stepExpect("espera_jogada", 4'h3);
            repeat ($urandom_range(maxWait, 0)) stepExpect("espera_hold", 4'h3);
            ok = !(r == errRound && j == errPlay);
            applyStimulus(0, 1, ok, j == r, r == nRounds - 1);
            stepExpect("registra", 4'h4);
            applyStimulus(0, 0, ok, j == r, r == nRounds - 1);
            stepExpect("comparacao", 4'h5);
            checkCounters("datapath", j, r);
            if (!ok) begin
               stepExpect("fim_errou", 4'hE);
               return;
            end
            if (j < r) stepExpect("proxima_jogada", 4'h6);
            else if (r == nRounds - 1) begin
               stepExpect("fim_acertou", 4'hA);
               return;
            end else begin
               stepExpect("proxima_rodada", 4'h7);
               stepExpect("inicia_rodada", 4'h2);
            end
         end
      end
   endtask

   initial begin
      int n, er, ep;
      reset = 1'b1;
      applyStimulus(0, 0, 0, 0, 0);
      #3;
      checkOutput("reset", 4'h0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      repeat (2) stepExpect("hold_inicial", 4'h0);

      $display("[TB] directed two-round win");
      playGame(2, -1, -1, 0);
      holdResult(4'hA);

      $display("[TB] directed error on first play");
      playGame(3, 0, 0, 0);
      holdResult(4'hE);

      $display("[TB] randomized games");
      repeat (12) begin
         n = $urandom_range(4, 1);
         if ($urandom_range(2, 0) == 0) begin
            er = $urandom_range(n - 1, 0);
            ep = $urandom_range(er, 0);
         end else begin
            er = -1;
            ep = -1;
         end
         playGame(n, er, ep, 3);
         holdResult((er < 0) ? 4'hA : 4'hE);
      end

      $display("[TB] asynchronous reset in comparacao");
      applyStimulus(1, 0, 0, 0, 0);
      stepExpect("preparacao", 4'h1);
      applyStimulus(0, 0, 0, 0, 0);
      stepExpect("inicia_rodada", 4'h2);
      stepExpect("espera_jogada", 4'h3);
      applyStimulus(0, 1, 1, 1, 1);
      stepExpect("registra", 4'h4);
      applyStimulus(0, 0, 1, 1, 1);
      stepExpect("comparacao", 4'h5);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_reset", 4'h0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      applyStimulus(0, 0, 0, 0, 0);
      stepExpect("after_reset", 4'h0);

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
      $display("[TB] timeout with no play");
      applyStimulus(1, 0, 0, 0, 0);
      stepExpect("preparacao", 4'h1);
      applyStimulus(0, 0, 0, 0, 0);
      stepExpect("inicia_rodada", 4'h2);
      stepExpect("espera_jogada", 4'h3);
      repeat (TO - 1) stepExpect("espera_count", 4'h3);
      stepExpect("fim_timeout", 4'hD);
      holdResult(4'hD);

      $display("[TB] play on the last allowed cycle");
      applyStimulus(1, 0, 0, 0, 0);
      stepExpect("preparacao", 4'h1);
      applyStimulus(0, 0, 0, 0, 0);
      stepExpect("inicia_rodada", 4'h2);
      stepExpect("espera_jogada", 4'h3);
      repeat (TO - 1) stepExpect("espera_count", 4'h3);
`else
      $display("[TB] long idle wait without timeout");
      applyStimulus(1, 0, 0, 0, 0);
      stepExpect("preparacao", 4'h1);
      applyStimulus(0, 0, 0, 0, 0);
      stepExpect("inicia_rodada", 4'h2);
      stepExpect("espera_jogada", 4'h3);
      repeat (10000) stepExpect("espera_idle", 4'h3);
`endif
      applyStimulus(0, 1, 1, 1, 1);
      stepExpect("registra_late", 4'h4);
      applyStimulus(0, 0, 1, 1, 1);
      stepExpect("comparacao_late", 4'h5);
      stepExpect("fim_acertou_late", 4'hA);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
